// File: rtl/cpu_pkg.sv
// Shared definitions for the MULT/DIV sequencer: op select codes, FSM state
// encoding, default datapath width and the latched operation context.
package cpu_pkg;

   localparam int unsigned MD_WIDTH = 32;

   localparam logic MD_OP_MULT = 1'b0;
   localparam logic MD_OP_DIV  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_MUL_RUN = 3'd1,
      ST_DIV_RUN = 3'd2,
      ST_FIX     = 3'd3,
      ST_DONE    = 3'd4,
      ST_ERR     = 3'd5
   } md_state_e;

   // Operation context captured when a request is accepted
   typedef struct packed {
      logic op;
      logic sign_a;
      logic sign_b;
   } md_ctx_t;

endpackage : cpu_pkg

// File: rtl/md_iter_step.sv
// Single combinational iteration of the unsigned multiply/divide datapath.
//   op      : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_hi  : upper accumulator (product high / partial remainder)
//   acc_lo  : lower accumulator (multiplier / dividend-quotient)
//   opnd    : multiplicand (MULT) or divisor (DIV) magnitude
//   hi_nxt, lo_nxt : accumulator pair after this iteration
module md_iter_step
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic             op,
   input  logic [WIDTH-1:0] acc_hi,
   input  logic [WIDTH-1:0] acc_lo,
   input  logic [WIDTH-1:0] opnd,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_s;
   logic [WIDTH-1:0] diff;

   always_comb begin
      hi_nxt = acc_hi;
      lo_nxt = acc_lo;
      sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      rem_s  = {acc_hi, acc_lo[WIDTH-1]};
      // Only consumed when rem_s >= opnd, where the result fits WIDTH bits
      diff   = rem_s[WIDTH-1:0] - opnd;
      if (op == MD_OP_MULT) begin
         // Conditional add, then shift the double-width accumulator right
         hi_nxt = sum[WIDTH:1];
         lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
      end else begin
         // Shift left, trial subtract, restore on negative
         if (rem_s >= {1'b0, opnd}) begin
            hi_nxt = diff;
            lo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = rem_s[WIDTH-1:0];
            lo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule : md_iter_step

// File: rtl/mult_div_sequencer.sv
// Multicycle MULT/DIV sequencer: latches operand magnitudes, runs WIDTH
// iterations of shift-add multiply or restoring divide, sign-corrects and
// loads HI/LO.
//   clk, reset_in      : clock, asynchronous active-low reset
//   start              : request, accepted only in IDLE
//   Div_Mult_Ctrl      : 0 = MULT, 1 = DIV (sampled with start)
//   A, B               : signed operands (rs, rt)
//   busy               : high from the cycle after acceptance until done
//   done               : one-cycle completion pulse
//   DIV0               : one-cycle divide-by-zero pulse, coincident with done
//   HI, LO             : MULT product high/low, DIV remainder/quotient
module mult_div_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic             start,
   input  logic             Div_Mult_Ctrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             DIV0,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   md_state_e          state, state_nxt;
   md_ctx_t            ctx;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] prod, prod_neg;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   logic               last_iter;

   // Operand magnitudes; the most negative value maps onto itself as unsigned
   assign a_mag     = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
   assign b_mag     = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
   assign last_iter = (cnt == CNT_W'(WIDTH-1));

   md_iter_step #(.WIDTH(WIDTH)) u_step (
      .op     (ctx.op),
      .acc_hi (acc_hi),
      .acc_lo (acc_lo),
      .opnd   (opnd),
      .hi_nxt (step_hi),
      .lo_nxt (step_lo)
   );

   // Sign correction of the unsigned result
   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_neg = -prod;
      fix_hi   = acc_hi;
      fix_lo   = acc_lo;
      if (ctx.op == MD_OP_MULT) begin
         if (ctx.sign_a ^ ctx.sign_b) begin
            fix_hi = prod_neg[2*WIDTH-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
         end
      end else begin
         if (ctx.sign_a ^ ctx.sign_b) fix_lo = -acc_lo;
         if (ctx.sign_a)              fix_hi = -acc_hi;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (Div_Mult_Ctrl == MD_OP_MULT) state_nxt = ST_MUL_RUN;
               else if (B == '0)                state_nxt = ST_ERR;
               else                             state_nxt = ST_DIV_RUN;
            end
         end
         ST_MUL_RUN,
         ST_DIV_RUN: if (last_iter) state_nxt = ST_FIX;
         ST_FIX:     state_nxt = ST_DONE;
         ST_DONE,
         ST_ERR:     state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Status outputs, registered from the next state so they track the FSM
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         busy <= 1'b0;
         done <= 1'b0;
         DIV0 <= 1'b0;
      end else begin
         busy <= (state_nxt != ST_IDLE);
         done <= (state_nxt == ST_DONE) || (state_nxt == ST_ERR);
         DIV0 <= (state_nxt == ST_ERR);
      end
   end

   // Operand latch, iteration datapath and result registers
   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         ctx    <= '0;
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
         HI     <= '0;
         LO     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  ctx.op     <= Div_Mult_Ctrl;
                  ctx.sign_a <= A[WIDTH-1];
                  ctx.sign_b <= B[WIDTH-1];
                  cnt        <= '0;
                  acc_hi     <= '0;
                  if (Div_Mult_Ctrl == MD_OP_DIV) begin
                     acc_lo <= a_mag;
                     opnd   <= b_mag;
                  end else begin
                     acc_lo <= b_mag;
                     opnd   <= a_mag;
                  end
               end
            end
            ST_MUL_RUN,
            ST_DIV_RUN: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt + CNT_W'(1);
            end
            ST_FIX: begin
               HI <= fix_hi;
               LO <= fix_lo;
            end
            default: ;
         endcase
      end
   end

endmodule : mult_div_sequencer

// File: tb/tb_mult_div_sequencer.sv
module tb_mult_div_sequencer;

   logic        clk = 1'b0;
   logic        reset_in;
   logic        start;
   logic        Div_Mult_Ctrl;
   logic [31:0] A, B;
   logic        busy, done, DIV0;
   logic [31:0] HI, LO;

   int checks = 0;
   int errors = 0;

   // Architectural HI/LO the bench expects the DUT to hold
   logic [31:0] exp_hi, exp_lo;

   always #5 clk = ~clk;

   mult_div_sequencer dut (
      .clk           (clk),
      .reset_in      (reset_in),
      .start         (start),
      .Div_Mult_Ctrl (Div_Mult_Ctrl),
      .A             (A),
      .B             (B),
      .busy          (busy),
      .done          (done),
      .DIV0          (DIV0),
      .HI            (HI),
      .LO            (LO)
   );

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Reference: signed arithmetic on 64-bit integers, returns {HI, LO}
   function automatic logic [63:0] ref_result(input logic op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!op) begin
         p = sa * sb;
         return p;
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Present a one-cycle start at the next negedge
   task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      A = a; B = b; Div_Mult_Ctrl = op; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called in cycle 1 after acceptance; scrambles A/B while waiting.
   task automatic wait_done(output int lat, output logic dz, output logic [31:0] hi, output logic [31:0] lo);
      lat = -1; dz = 1'bx; hi = 'x; lo = 'x;
      for (int c = 1; c <= 40; c++) begin
         if (done === 1'b1) begin
            lat = c; dz = DIV0; hi = HI; lo = LO;
            break;
         end
         A = $urandom; B = $urandom;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset_in = 1'b0; start = 1'b0; Div_Mult_Ctrl = 1'b0; A = '0; B = '0;
      repeat (3) @(negedge clk);
      checks++; if ({busy, done, DIV0} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, DIV0}); end
      checks++; if ({HI, LO} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h exp 0", {HI, LO}); end
      reset_in = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if ({busy, done, HI, LO} !== 66'h0) begin errors++; $display("FAIL post_reset_idle got %h exp 0", {busy, done, HI, LO}); end
      exp_hi = '0; exp_lo = '0;
   endtask

   task automatic test_mult();
      logic [31:0] da [4] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF};
      logic [31:0] db [4] = '{32'h0000_0003, 32'h8000_0000, 32'h1234_5678, 32'h8000_0000};
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a, b, hi, lo;
         logic [63:0] r;
         logic dz;
         int lat;
         a = (i < 4) ? da[i] : $urandom;
         b = (i < 4) ? db[i] : $urandom;
         issue(1'b0, a, b);
         wait_done(lat, dz, hi, lo);
         r = ref_result(1'b0, a, b);
         exp_hi = r[63:32]; exp_lo = r[31:0];
         checks++; if (lat !== 34) begin errors++; $display("FAIL mult_latency a=%h b=%h got %0d exp 34", a, b, lat); end
         checks++; if (dz !== 1'b0) begin errors++; $display("FAIL mult_div0 got %b exp 0", dz); end
         checks++; if ({hi, lo} !== r) begin errors++; $display("FAIL mult_result a=%h b=%h got %h exp %h", a, b, {hi, lo}, r); end
         @(negedge clk);
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_after got %b exp 0", busy); end
      end
   endtask

   task automatic test_div();
      logic [31:0] da [4] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] db [4] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a, b, hi, lo;
         logic [63:0] r;
         logic dz;
         int lat;
         a = (i < 4) ? da[i] : $urandom;
         b = (i < 4) ? db[i] : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
         if (b == 0) b = 32'd1;
         issue(1'b1, a, b);
         wait_done(lat, dz, hi, lo);
         r = ref_result(1'b1, a, b);
         exp_hi = r[63:32]; exp_lo = r[31:0];
         checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency a=%h b=%h got %0d exp 34", a, b, lat); end
         checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_div0 got %b exp 0", dz); end
         checks++; if ({hi, lo} !== r) begin errors++; $display("FAIL div_result a=%h b=%h got %h exp %h", a, b, {hi, lo}, r); end
      end
   endtask

   task automatic test_div0();
      logic [31:0] hi, lo;
      logic dz;
      int lat;
      issue(1'b1, 32'd5, 32'd0);
      wait_done(lat, dz, hi, lo);
      checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency got %0d exp 1", lat); end
      checks++; if (dz !== 1'b1) begin errors++; $display("FAIL div0_flag got %b exp 1", dz); end
      checks++; if ({hi, lo} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL div0_hilo_kept got %h exp %h", {hi, lo}, {exp_hi, exp_lo}); end
      @(negedge clk);
      checks++; if ({busy, done, DIV0} !== 3'b000) begin errors++; $display("FAIL div0_return_idle got %b exp 000", {busy, done, DIV0}); end
   endtask

   task automatic test_idle_hold();
      repeat (20) @(negedge clk);
      checks++; if ({HI, LO} !== {exp_hi, exp_lo}) begin errors++; $display("FAIL idle_hold got %h exp %h", {HI, LO}, {exp_hi, exp_lo}); end
   endtask

   task automatic test_restart_ignored();
      int ndone = 0, first = -1;
      logic [31:0] hi = '0, lo = '0;
      issue(1'b0, 32'd6, 32'd7);
      for (int c = 1; c <= 45; c++) begin
         if (done === 1'b1) begin
            ndone++;
            if (first < 0) begin first = c; hi = HI; lo = LO; end
         end
         if (c == 10) begin start = 1'b1; A = 32'd100; B = 32'd5; Div_Mult_Ctrl = 1'b1; end
         else start = 1'b0;
         @(negedge clk);
      end
      exp_hi = 32'd0; exp_lo = 32'd42;
      checks++; if (ndone !== 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", ndone); end
      checks++; if (first !== 34) begin errors++; $display("FAIL restart_latency got %0d exp 34", first); end
      checks++; if ({hi, lo} !== 64'd42) begin errors++; $display("FAIL restart_result got %h exp %h", {hi, lo}, 64'd42); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] hi, lo, a2, b2;
      logic [63:0] r;
      logic dz;
      int lat;
      issue(1'b0, $urandom, $urandom);
      wait_done(lat, dz, hi, lo);
      // Request raised during the done cycle must be ignored
      a2 = $urandom; b2 = $urandom | 32'h1;
      A = a2; B = b2; Div_Mult_Ctrl = 1'b1; start = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done got busy=%b exp 0", busy); end
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, dz, hi, lo);
      r = ref_result(1'b1, a2, b2);
      exp_hi = r[63:32]; exp_lo = r[31:0];
      checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got %0d exp 34", lat); end
      checks++; if ({hi, lo} !== r) begin errors++; $display("FAIL b2b_result got %h exp %h", {hi, lo}, r); end
   endtask

   task automatic test_async_reset();
      int ndone = 0;
      logic [31:0] hi, lo;
      logic dz;
      int lat;
      issue(1'b1, $urandom, $urandom | 32'h1);
      repeat (14) @(negedge clk);
      reset_in = 1'b0;
      #1;
      checks++; if ({busy, done, HI, LO} !== 66'h0) begin errors++; $display("FAIL areset_immediate got %h exp 0", {busy, done, HI, LO}); end
      @(negedge clk);
      reset_in = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (done === 1'b1) ndone++;
         @(negedge clk);
      end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL areset_no_done got %0d exp 0", ndone); end
      issue(1'b1, 32'd100, 32'd7);
      wait_done(lat, dz, hi, lo);
      checks++; if (lat !== 34) begin errors++; $display("FAIL areset_fresh_latency got %0d exp 34", lat); end
      checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL areset_fresh_result got %h exp %h", {hi, lo}, {32'd2, 32'd14}); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div0();
      test_idle_hold();
      test_restart_ignored();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_mult_div_sequencer
